// File: rtl/rr_dispatcher_pkg.sv
// Shared constants and types for the two-channel round-robin dispatcher.
package rr_dispatcher_pkg;
   localparam int NUM_CH = 2;
   typedef logic [$clog2(NUM_CH)-1:0] ch_idx_t;
endpackage

// File: rtl/rr_dispatcher_if.sv
// Stream bundle: one valid/ready input stream fanned out to NUM_CH output channels.
interface rr_dispatcher_if
   import rr_dispatcher_pkg::*;
#(
   parameter int BIT_DEPTH = 8
);
   logic [BIT_DEPTH-1:0] t_data_i;
   logic                 t_valid_i;
   logic                 t_ready_o;
   logic [BIT_DEPTH-1:0] t_data_o [NUM_CH];
   logic [NUM_CH-1:0]    t_valid_o;
   logic [NUM_CH-1:0]    t_ready_i;

   // The dispatcher side of the bundle.
   modport slave (
      input  t_data_i, t_valid_i, t_ready_i,
      output t_ready_o, t_data_o, t_valid_o
   );

   // The producer/consumer side that surrounds the dispatcher.
   modport master (
      output t_data_i, t_valid_i, t_ready_i,
      input  t_ready_o, t_data_o, t_valid_o
   );
endinterface

// File: rtl/rr_dispatcher_slot.sv
// One-entry holding register for a single output channel; can drain and refill
// in the same cycle.
module dispatch_slot
   import rr_dispatcher_pkg::*;
#(
   parameter int BIT_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 arstn,
   input  logic                 load,
   input  logic [BIT_DEPTH-1:0] d,
   input  logic                 ready_i,
   output logic                 valid_o,
   output logic [BIT_DEPTH-1:0] q,
   output logic                 free_o
);
   logic                 vld_reg;
   logic [BIT_DEPTH-1:0] dat_reg;

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         vld_reg <= 1'b0;
         dat_reg <= '0;
      end else if (load) begin
         vld_reg <= 1'b1;
         dat_reg <= d;
      end else if (ready_i) begin
         vld_reg <= 1'b0;
      end
   end

   assign valid_o = vld_reg;
   assign q       = dat_reg;
   assign free_o  = !vld_reg || ready_i;
endmodule

// File: rtl/rr_dispatcher.sv
// Round-robin fan-out of one stream onto two registered channels; the pointer
// prefers the channel that did not take the last word.
module rr_dispatcher
   import rr_dispatcher_pkg::*;
#(
   parameter int BIT_DEPTH = 8
) (
   input logic            clk,
   input logic            arstn,
   rr_dispatcher_if.slave bus
);
   logic [NUM_CH-1:0]    free;
   logic [NUM_CH-1:0]    load;
   logic [NUM_CH-1:0]    valid_w;
   logic [BIT_DEPTH-1:0] q_w [NUM_CH];
   ch_idx_t              ptr_reg;
   ch_idx_t              ptr_next;
   ch_idx_t              tgt;
   logic                 xfer;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
         assign load[gi] = xfer && (tgt == ch_idx_t'(gi));

         dispatch_slot #(
            .BIT_DEPTH (BIT_DEPTH)
         ) u_slot (
            .clk     (clk),
            .arstn   (arstn),
            .load    (load[gi]),
            .d       (bus.t_data_i),
            .ready_i (bus.t_ready_i[gi]),
            .valid_o (valid_w[gi]),
            .q       (q_w[gi]),
            .free_o  (free[gi])
         );

         assign bus.t_data_o[gi] = q_w[gi];
      end
   endgenerate

   assign bus.t_valid_o = valid_w;
   assign bus.t_ready_o = |free;
   assign xfer          = bus.t_valid_i && bus.t_ready_o;

   // When neither channel is free, tgt is a don't-care because xfer is low.
   always_comb begin
      tgt = ptr_reg;
      if (!free[ptr_reg] && free[~ptr_reg]) begin
         tgt = ~ptr_reg;
      end
      ptr_next = xfer ? ~tgt : ptr_reg;
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         ptr_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end
endmodule
